// File: rtl/c17_bist_ctrl.sv
// BIST controller for the c17 core: LFSR pattern source, MISR response
// compactor and golden-signature compare, sequenced by an IDLE/RUN/DONE FSM.
module c17_bist_ctrl #(
  parameter int unsigned N_PATTERNS = 31,
  parameter logic [4:0]  SEED       = 5'b00001,
  parameter logic [7:0]  GOLDEN     = 8'h00
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] resp_in,
  output logic [4:0] pat_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [4:0] LAST = 5'(N_PATTERNS - 1);

  state_e     state_q, state_d;
  logic [4:0] lfsr_q, lfsr_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] sig_q, sig_d;

  logic       lfsr_fb;
  logic       misr_fb;
  logic [7:0] misr_nxt;

  assign lfsr_fb  = lfsr_q[4] ^ lfsr_q[2];
  assign misr_fb  = sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3];
  assign misr_nxt = {sig_q[6:0], misr_fb} ^ {6'b0, resp_in};

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  // abort outranks everything; it keeps sig/lfsr so the partial
  // signature stays observable after the run is stopped
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_RUN;
            lfsr_d  = SEED;
            cnt_d   = '0;
            sig_d   = '0;
          end
        end
        S_RUN: begin
          sig_d  = misr_nxt;
          lfsr_d = {lfsr_q[3:0], lfsr_fb};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pat_out = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_RUN: begin
        pat_out = lfsr_q;
        busy    = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    pass = done & (sig_q == GOLDEN);
  end

  assign signature = sig_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Bench for c17_bist_ctrl: real c17 model on the response path, vector
// table, hand sequences and randomized control against a behavioural model.
module tb_c17_bist_ctrl;

  function automatic logic [1:0] c17(input logic [4:0] p);
    logic g1, g2, g3, g6, g7, g10, g11, g16, g19;
    {g1, g2, g3, g6, g7} = p;
    g10 = ~(g1 & g3);
    g11 = ~(g3 & g6);
    g16 = ~(g2 & g11);
    g19 = ~(g11 & g7);
    return {~(g10 & g16), ~(g16 & g19)};
  endfunction

  function automatic int nxt_pat(input int l);
    return ((l * 2) % 32) | (((l >> 4) ^ (l >> 2)) & 1);
  endfunction

  function automatic int compact(input int s, input int r);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    return (((s * 2) % 256) | fb) ^ r;
  endfunction

  // fpat = 0 means no fault (the pattern source never produces 0)
  function automatic logic [7:0] calc_sig(input int n, input int fpat);
    int l, s, r;
    l = 1;
    s = 0;
    for (int i = 0; i < n; i++) begin
      r = int'(c17(5'(l)));
      if (l == fpat) r = r & 1;
      s = compact(s, r);
      l = nxt_pat(l);
    end
    return 8'(s);
  endfunction

  localparam logic [7:0] GOLD  = calc_sig(31, 0);
  localparam logic [7:0] GOLD1 = calc_sig(1, 0);

  logic CK = 1'b0;
  logic RN = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [1:0] resp_in, resp1;
  logic [4:0] pat_out, pat1;
  logic busy, done, pass, busy1, done1, pass1;
  logic [7:0] signature, sig1;

  int mode = 0;
  logic [1:0] rnd_resp = 2'b00;
  logic [4:0] fpat = 5'd0;

  always #5 CK = ~CK;

  assign resp_in = (mode == 1) ? rnd_resp :
                   (mode == 2) ? 2'b00 :
                   (mode == 3 && pat_out == fpat) ? (c17(pat_out) & 2'b01) :
                   c17(pat_out);
  assign resp1 = c17(pat1);

  c17_bist_ctrl #(.N_PATTERNS(31), .SEED(5'b00001), .GOLDEN(GOLD)) u_dut (
    .CK(CK), .RN(RN), .start(start), .abort(abort), .resp_in(resp_in),
    .pat_out(pat_out), .busy(busy), .done(done), .pass(pass),
    .signature(signature)
  );

  c17_bist_ctrl #(.N_PATTERNS(1), .SEED(5'b00001), .GOLDEN(GOLD1)) u_one (
    .CK(CK), .RN(RN), .start(start), .abort(abort), .resp_in(resp1),
    .pat_out(pat1), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1)
  );

  int n_chk = 0;
  int n_fail = 0;

  // model: st 0=idle 1=running 2=finished
  int m_st = 0;
  int m_l = 1;
  int m_c = 0;
  int m_s = 0;
  logic [7:0] m_gold = GOLD;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic int model_resp();
    int r;
    r = int'(c17(5'(m_l)));
    if (mode == 1) r = int'(rnd_resp);
    else if (mode == 2) r = 0;
    else if (mode == 3 && m_l == int'(fpat)) r = r & 1;
    return r;
  endfunction

  task automatic check_outs(input string nm);
    logic [15:0] exp, got;
    exp = {(m_st == 1) ? 5'(m_l) : 5'd0, m_st == 1, m_st == 2,
           (m_st == 2) && (8'(m_s) == m_gold), 8'(m_s)};
    got = {pat_out, busy, done, pass, signature};
    check(nm, 32'(got), 32'(exp));
  endtask

  task automatic cyc();
    int st, l, c, s;
    st = m_st; l = m_l; c = m_c; s = m_s;
    if (abort) begin
      st = 0;
      c = 0;
    end else if (m_st == 1) begin
      s = compact(m_s, model_resp());
      l = nxt_pat(m_l);
      if (m_c == 30) st = 2;
      c = m_c + 1;
    end else if (start) begin
      st = 1; l = 1; c = 0; s = 0;
    end
    @(posedge CK);
    #1;
    m_st = st; m_l = l; m_c = c; m_s = s;
    check_outs("outs");
  endtask

  task automatic model_reset();
    m_st = 0; m_l = 1; m_c = 0; m_s = 0;
  endtask

  task automatic run_to_done();
    for (int k = 0; k < 40 && m_st != 2; k++) cyc();
    check("reach_done", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic       st;
    logic       ab;
    logic [4:0] pat;
    logic       bsy;
  } vec_t;

  vec_t tv[6];
  logic seen[32];
  int bcnt, ndist;

  initial begin
    tv[0] = '{1'b1, 1'b0, 5'b00001, 1'b1};
    tv[1] = '{1'b0, 1'b0, 5'b00010, 1'b1};
    tv[2] = '{1'b1, 1'b0, 5'b00100, 1'b1};
    tv[3] = '{1'b0, 1'b0, 5'b01001, 1'b1};
    tv[4] = '{1'b0, 1'b0, 5'b10010, 1'b1};
    tv[5] = '{1'b0, 1'b0, 5'b00101, 1'b1};
    for (int p = 31; p >= 1; p--) begin
      if (c17(5'(p))[1] == 1'b1) fpat = 5'(p);
    end

    // reset and idle
    #2;
    model_reset();
    check_outs("reset");
    @(negedge CK);
    RN = 1'b1;
    for (int i = 0; i < 5; i++) cyc();

    // vector table: pattern sequence, start ignored in RUN, N=1 instance
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      start = tv[i].st;
      abort = tv[i].ab;
      cyc();
      check("tv_pat", 32'(pat_out), 32'(tv[i].pat));
      check("tv_busy", 32'(busy), 32'(tv[i].bsy));
      if (busy) begin
        bcnt++;
        seen[pat_out] = 1'b1;
      end
      if (i == 0) check("one_run", 32'({busy1, done1, pat1}), 32'({2'b10, 5'b00001}));
      if (i == 1) check("one_done", 32'({busy1, done1, pass1, sig1}), 32'({3'b011, GOLD1}));
    end
    start = 1'b0;
    for (int k = 0; k < 40 && m_st != 2; k++) begin
      cyc();
      if (busy) begin
        bcnt++;
        seen[pat_out] = 1'b1;
      end
    end
    ndist = 0;
    for (int i = 1; i < 32; i++) if (seen[i]) ndist++;
    check("busy_cycles", 32'(bcnt), 32'd31);
    check("distinct_pats", 32'(ndist), 32'd31);
    check("seen_zero", 32'(seen[0]), 32'd0);
    check("golden_pass", 32'({done, pass, signature}), 32'({2'b11, GOLD}));

    // restart from DONE clears the signature
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_sig", 32'(signature), 32'd0);
    run_to_done();
    check("rerun_pass", 32'(pass), 32'd1);

    // abort together with start at RUN cycle 10
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    check("abort_idle", 32'({busy, done, pat_out}), 32'd0);
    cyc();

    // single-pattern fault on G22
    mode = 3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_to_done();
    check("fault_pass", 32'(pass), 32'd0);
    check("fault_sig", 32'(signature), 32'(calc_sig(31, int'(fpat))));
    check("fault_neq", 32'(signature != GOLD), 32'd1);

    // responses tied low
    mode = 2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_to_done();
    check("zero_sig", 32'(signature), 32'd0);

    // async reset mid-run
    mode = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    @(negedge CK);
    RN = 1'b0;
    #1;
    model_reset();
    check_outs("mid_reset");
    #1;
    RN = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_to_done();
    check("post_reset_sig", 32'({pass, signature}), 32'({1'b1, GOLD}));

    // randomized control and responses
    mode = 1;
    for (int i = 0; i < 400; i++) begin
      rnd_resp = 2'($urandom);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 19) == 0);
      cyc();
    end
    start = 1'b0;
    abort = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
